instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction-fetch front end: owns the fetch PC, issues in-order word reads to instruction
//  memory, buffers returned words with their PCs, and presents them to decode as instr_raw.
//  Handles redirects: in-flight responses are discarded and the buffer is flushed.
//  Sits between imem and decode; it is the producer of decode's instr_raw.
// PARAMETERS
//  RESET_PC        32'h0000_0000  fetch PC after reset
//  FIFO_DEPTH      4              instr buffer entries (power of 2, >=2)
//  MAX_OUTSTANDING 2              max accepted-but-unanswered imem requests
// PORTS
//  clock           in   1   system clock, rising edge
//  reset           in   1   asynchronous, active-low reset
//  imem_req_valid  out  1   read request valid
//  imem_req_ready  in   1   imem accepts request this cycle
//  imem_req_addr   out  32  word address (byte addr, [1:0]=0)
//  imem_rsp_valid  in   1   read data valid; in-order, one per accepted req, latency >=1
//  imem_rsp_data   in   32  read data
//  redirect_valid  in   1   branch/jump taken; single-cycle pulse
//  redirect_pc     in   32  new fetch PC
//  instr_valid     out  1   instr_raw/instr_pc valid to decode
//  instr_ready     in   1   decode consumes instr this cycle
//  instr_raw       out  32  instruction word
//  instr_pc        out  32  PC of instr_raw
//  misaligned      out  1   sticky: redirect_pc[1:0]!=0 seen; fetch halted
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, rsp_pc=RESET_PC, inflight=0, drop_cnt=0, FIFO empty;
//   imem_req_valid=0, instr_valid=0, instr_raw=0, instr_pc=0, misaligned=0.
//  Issue: imem_req_valid = !misaligned && !redirect_valid && inflight<MAX_OUTSTANDING
//   && (inflight-drop_cnt)+fifo_count < FIFO_DEPTH (credit; all counts registered).
//   imem_req_addr=fetch_pc. On valid&&ready: fetch_pc+=4 (32-bit wrap), inflight+1.
//   Request held stable while valid&&!ready.
//  Response: each imem_rsp_valid decrements inflight. If drop_cnt>0: discard, drop_cnt-1.
//   Else push {rsp_pc, data} into FIFO, rsp_pc+=4. Credit guarantees no overflow (assert).
//  Output: instr_valid = FIFO non-empty; instr_raw/instr_pc = head (registered, no bypass:
//   rsp in cycle N -> instr_valid earliest N+1). Pop on instr_valid&&instr_ready.
//   With 1-cycle imem and instr_ready=1 sustained, throughput is 1 instr/cycle.
//  Redirect (cycle R, highest priority): FIFO flushed (any pop in R ignored), fetch_pc and
//   rsp_pc <= redirect_pc, no request issued in R, drop_cnt <= inflight after R
//   (response arriving in R is discarded and excluded). instr_valid=0 in R+1; first new
//   request in R+1.
//  Misaligned redirect: flush as above, misaligned<=1, no further requests; cleared by reset
//   or a later aligned redirect (which restarts fetch normally).
//  Mid-operation reset: all state returns to reset values immediately (async).
// STRUCTURE
//  def.v: add `RESET_PC_DEFAULT, `INSTR_NOP (32'h0000_0013), `XLEN (32).
//  Sub-module instr_fifo: sync FIFO, 64-bit entries {pc,instr}, push/pop/flush, count/empty;
//   flush overrides push and pop. Counters/drop logic stay in instr_fetch.
// TESTING
//  Reset release, imem ready=1, 1-cycle latency, data=addr^32'hA5A5A5A5 -> instr_pc 0,4,8,...
//   back-to-back, instr_raw matches, one instr/cycle after fill.
//  instr_ready=0 for 10 cycles -> FIFO fills to 4, imem_req_valid=0, no drops; release ->
//   PCs continue contiguous.
//  imem_req_ready toggled randomly, latency 3 -> addr stable while stalled, no gaps/dups.
//  Redirect to 32'h100 with 2 requests in flight -> both stale rsps dropped, next instr_pc=0x100,
//   instr_valid=0 cycle after redirect.
//  Redirect to 32'h102 -> misaligned=1, req stops; later redirect to 32'h200 -> misaligned=0,
//   fetch resumes at 0x200.
//  Reset asserted with FIFO full and requests outstanding -> outputs zero immediately; after
//   release first req addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// The buffer entry layout {pc, instr} is defined once here so the FIFO and its user agree on it.
package instr_fetch_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam int              ENTRY_W          = 2 * XLEN;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

  function automatic fetch_entry_t make_entry(input logic [XLEN-1:0] pc,
                                              input logic [XLEN-1:0] instr);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous instruction buffer holding {pc, instr} entries.
// Flush overrides push and pop; the head reads as zero whenever the buffer is empty.
module instr_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [ENTRY_W-1:0]       wdata_i,
  output logic [ENTRY_W-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers/count define validity and rdata_o is gated by empty.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: owns the fetch PC, issues in-order imem reads under a credit limit,
// buffers returned words with their PCs and discards responses made stale by a redirect.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_raw,
  output logic [XLEN-1:0] instr_pc,
  output logic            misaligned
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [OW-1:0]   inflight_q, inflight_d;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            misaligned_q, misaligned_d;
  logic            fetch_en_q;

  logic            req_fire, has_slot, has_credit;
  logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_head;
  logic [ENTRY_W-1:0] fifo_head_bits;

  // Responses still owed to the buffer (inflight minus those to be dropped) count against its space.
  assign has_slot   = int'(inflight_q) < MAX_OUTSTANDING;
  assign has_credit = (int'(inflight_q) - int'(drop_cnt_q) + int'(fifo_count)) < FIFO_DEPTH;

  assign imem_req_valid = fetch_en_q && !misaligned_q && !redirect_valid && has_slot && has_credit;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign fifo_head   = fetch_entry_t'(fifo_head_bits);
  assign instr_valid = !fifo_empty;
  assign instr_raw   = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;
  assign misaligned  = misaligned_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    rsp_pc_d     = rsp_pc_q;
    inflight_d   = inflight_q;
    drop_cnt_d   = drop_cnt_q;
    misaligned_d = misaligned_q;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      fetch_pc_d   = redirect_pc;
      rsp_pc_d     = redirect_pc;
      misaligned_d = pc_misaligned(redirect_pc);
      inflight_d   = inflight_q - OW'(imem_rsp_valid);
      drop_cnt_d   = inflight_q - OW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      inflight_d = inflight_q + OW'(req_fire) - OW'(imem_rsp_valid);
      if (imem_rsp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - 1'b1;
        end else begin
          fifo_push = 1'b1;
          rsp_pc_d  = rsp_pc_q + PC_STEP;
        end
      end
      fifo_pop = instr_valid && instr_ready;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q   <= RESET_PC;
      rsp_pc_q     <= RESET_PC;
      inflight_q   <= '0;
      drop_cnt_q   <= '0;
      misaligned_q <= 1'b0;
      fetch_en_q   <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      rsp_pc_q     <= rsp_pc_d;
      inflight_q   <= inflight_d;
      drop_cnt_q   <= drop_cnt_d;
      misaligned_q <= misaligned_d;
      fetch_en_q   <= 1'b1;
    end
  end

  instr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (redirect_valid),
    .wdata_i (make_entry(rsp_pc_q, imem_rsp_data)),
    .rdata_o (fifo_head_bits),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset) fifo_push |-> !fifo_full);

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: a behavioural imem plus an in-order
// expected-instruction queue that is rebuilt from the architectural PC on every redirect.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DATA_KEY = 32'hA5A5_A5A5;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_raw;
  logic [31:0] instr_pc;
  logic        misaligned;

  instr_fetch #(
    .RESET_PC        (RESET_PC),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_raw      (instr_raw),
    .instr_pc       (instr_pc),
    .misaligned     (misaligned)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] raw; } exp_t;

  pend_t       pending[$];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          rr_mode  = 0;   // 0: imem always ready, 1: random, 2: never
  int          ir_mode  = 0;   // 0: decode always ready, 1: never, 2: random
  bit          redir_now = 1'b0;
  logic [31:0] redir_target = '0;
  logic [31:0] model_pc = RESET_PC;
  bit          mis_model = 1'b0;
  bit          prev_stall = 1'b0;
  bit          prev_redir = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: drive inputs at the falling edge, then sample settled outputs 1 time unit later.
  task automatic step();
    @(negedge clock);
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pending[0].addr ^ DATA_KEY;
      void'(pending.pop_front());
    end
    imem_req_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    instr_ready    = (ir_mode == 0) ? 1'b1 : (ir_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    redirect_valid = redir_now;
    redirect_pc    = redir_now ? redir_target : $urandom;
    #1;
    check("misaligned_flag", 32'(misaligned), 32'(mis_model));
    if (mis_model) check("halted_no_req", 32'(imem_req_valid), 0);
    if (redirect_valid) check("no_req_in_redirect", 32'(imem_req_valid), 0);
    if (prev_redir) check("valid_low_after_redirect", 32'(instr_valid), 0);
    if (prev_stall && !prev_redir && !redirect_valid) begin
      check("req_held_valid", 32'(imem_req_valid), 1);
      check("req_held_addr", imem_req_addr, prev_addr);
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, model_pc);
      pending.push_back('{addr: imem_req_addr, due: cyc + lat});
      exp_q.push_back('{pc: model_pc, raw: model_pc ^ DATA_KEY});
      model_pc = model_pc + 32'd4;
    end
    prev_stall = imem_req_valid && !imem_req_ready;
    prev_addr  = imem_req_addr;
    prev_redir = redirect_valid;
    if (redirect_valid) begin
      exp_q.delete();
      model_pc  = redirect_pc;
      mis_model = (redirect_pc[1:0] != 2'b00);
    end
    redir_now = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redir_now    = 1'b1;
    redir_target = target;
    step();
  endtask

  // Monitor: every instruction decode accepts must be the next one the model expects.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (reset && !redirect_valid && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          check("instr_unexpected", 32'(instr_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr_raw", instr_raw, e.raw);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int  cnt;
    bit  found;
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_instr_valid", 32'(instr_valid), 0);
    check("rst_instr_raw", instr_raw, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_misaligned", 32'(misaligned), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Streaming with 1-cycle imem: after fill, one instruction per cycle.
    lat = 1; rr_mode = 0; ir_mode = 0;
    repeat (6) step();
    cnt = 0;
    repeat (20) begin
      step();
      cnt += int'(instr_valid);
    end
    check("throughput_valid_cycles", 32'(cnt), 20);

    // Decode stalls: buffer fills to its depth and fetch stops issuing.
    ir_mode = 1;
    repeat (10) step();
    check("full_req_valid", 32'(imem_req_valid), 0);
    check("full_instr_valid", 32'(instr_valid), 1);
    check("full_buffered", 32'(exp_q.size()), 4);
    check("full_nothing_inflight", 32'(pending.size()), 0);
    ir_mode = 0;
    repeat (10) step();

    // Random imem backpressure with 3-cycle latency, then random decode backpressure too.
    lat = 3; rr_mode = 1;
    repeat (60) step();
    ir_mode = 2;
    repeat (60) step();

    // Redirect with two requests in flight.
    rr_mode = 0; ir_mode = 0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      found = (pending.size() == 2);
    end
    check("two_inflight_setup", 32'(found), 1);
    redirect_to(32'h0000_0100);
    repeat (20) step();

    // Misaligned redirect halts fetch; a later aligned redirect resumes it.
    redirect_to(32'h0000_0102);
    repeat (10) step();
    check("halt_buffer_empty", 32'(instr_valid), 0);
    redirect_to(32'h0000_0200);
    repeat (20) step();

    // Random traffic with random (occasionally misaligned) redirects and latencies.
    rr_mode = 1; ir_mode = 2;
    for (int i = 0; i < 160; i++) begin
      if (i % 25 == 0) lat = $urandom_range(1, 4);
      if ($urandom_range(0, 15) == 0) begin
        redir_target = $urandom;
        if ($urandom_range(0, 3) != 0) redir_target[1:0] = 2'b00;
        redir_now = 1'b1;
      end
      step();
    end

    // Asynchronous reset in the middle of traffic.
    lat = 3; rr_mode = 0; ir_mode = 1;
    redirect_to(32'h0000_0400);
    repeat (6) step();
    #2;
    reset          = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("async_rst_req_valid", 32'(imem_req_valid), 0);
    check("async_rst_instr_valid", 32'(instr_valid), 0);
    check("async_rst_instr_raw", instr_raw, 0);
    check("async_rst_instr_pc", instr_pc, 0);
    check("async_rst_misaligned", 32'(misaligned), 0);
    pending.delete();
    exp_q.delete();
    model_pc   = RESET_PC;
    mis_model  = 1'b0;
    prev_stall = 1'b0;
    prev_redir = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    ir_mode = 0;
    step();
    check("post_rst_req_valid", 32'(imem_req_valid), 1);
    check("post_rst_req_addr", imem_req_addr, RESET_PC);
    repeat (20) step();

    // Drain: stop issuing, let responses return and decode empty the buffer.
    rr_mode = 2;
    repeat (30) step();
    check("drain_expected_empty", 32'(exp_q.size()), 0);
    check("drain_imem_idle", 32'(pending.size()), 0);
    check("drain_instr_valid", 32'(instr_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
